mci_cif_arb: RTL and testbench

MCI_CIF_ARB -- requirements
Module: mci_cif_arb

---
 rtl/mci_pkg.sv | 23 ++
 rtl/cif_if.sv | 11 +
 rtl/mci_cif_arb_wdt.sv | 20 ++
 rtl/mci_cif_arb.sv | 63 ++++++
 tb/tb_mci_cif_arb.sv | 131 +++++++++++++
 5 files changed

// File: rtl/mci_pkg.sv
// mci_pkg: shared types, defaults and response helper for the MCI CIF arbiter
package mci_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} mci_cif_arb_state_e;
  localparam int MCI_CIF_ARB_TIMEOUT_DEFAULT = 256;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } cif_req_t;
  typedef struct packed {
    logic        req_hold;
    logic [31:0] rdata;
    logic        error;
  } cif_rsp_t;
  function automatic cif_rsp_t cif_rsp(logic dv, logic gnt, logic abort, cif_rsp_t tgt);
    cif_rsp_t r;
    r = '0;
    if (dv && !gnt) r.req_hold = 1'b1;
    else if (dv && abort) r.error = 1'b1;
    else if (dv) r = tgt;
    return r;
  endfunction
endpackage

// File: rtl/cif_if.sv
// cif_if: CIF request/response handshake bundle
interface cif_if;
  import mci_pkg::*;
  logic        dv;
  cif_req_t    req_data;
  logic        req_hold;
  logic [31:0] rdata;
  logic        error;
  modport request(output dv, req_data, input req_hold, rdata, error);
  modport response(input dv, req_data, output req_hold, rdata, error);
endinterface

// File: rtl/mci_cif_arb_wdt.sv
// mci_cif_arb_wdt: saturating hold-cycle counter that flags expiry
module mci_cif_arb_wdt
  import mci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MCI_CIF_ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (!rst_b || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mci_cif_arb.sv
// mci_cif_arb: two-requester round-robin CIF arbiter; MCI_CIF_ARB_HOLD_TIMEOUT_EN adds hold timeout
module mci_cif_arb
  import mci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MCI_CIF_ARB_TIMEOUT_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_b,
  cif_if.response req0_if,
  cif_if.response req1_if,
  cif_if.request  tgt_if,
  output logic    grant_id,
  output logic    arb_busy,
  output logic    timeout_err
);
  mci_cif_arb_state_e state_q, state_d;
  logic       rr_q, rr_d, win, expired, abort, done;
  logic [1:0] dv, gnt;
  cif_rsp_t   trsp, rsp0, rsp1;
  assign dv  = {req1_if.dv, req0_if.dv};
  assign win = state_q == GNT1 ? 1'b1 : state_q == GNT0 ? 1'b0 : &dv ? rr_q : dv[1];
  assign gnt = (state_q != IDLE || |dv) ? 2'b01 << win : 2'b00;
  assign abort = expired & (state_q != IDLE) & rst_b;
  assign tgt_if.dv       = |(gnt & dv) & ~abort;
  assign tgt_if.req_data = win ? req1_if.req_data : req0_if.req_data;
  assign trsp = {tgt_if.req_hold, tgt_if.rdata, tgt_if.error};
  assign rsp0 = cif_rsp(dv[0], gnt[0], abort, trsp);
  assign rsp1 = cif_rsp(dv[1], gnt[1], abort, trsp);
  assign {req0_if.req_hold, req0_if.rdata, req0_if.error} = rsp0;
  assign {req1_if.req_hold, req1_if.rdata, req1_if.error} = rsp1;
  assign grant_id    = win;
  assign arb_busy    = state_q != IDLE;
  assign timeout_err = abort;
  always_comb begin
    done    = state_q == IDLE ? tgt_if.dv & ~tgt_if.req_hold : abort | ~tgt_if.req_hold;
    state_d = done ? IDLE : state_q != IDLE ? state_q : tgt_if.dv ? (win ? GNT1 : GNT0) : IDLE;
    rr_d    = done ? ~win : rr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end
`ifdef MCI_CIF_ARB_HOLD_TIMEOUT_EN
  mci_cif_arb_wdt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .clk,
    .rst_b,
    .en     (state_q != IDLE && tgt_if.req_hold),
    .clr    (state_q == IDLE || done),
    .expired
  );
`else
  assign expired = 1'b0;
`endif
  a_cfg:  assert property (@(posedge clk) TIMEOUT_CYCLES >= 2 && TIMEOUT_CYCLES <= 65535);
  a_gnt:  assert property (@(posedge clk) disable iff (!rst_b) $onehot0(gnt));
  a_dv:   assert property (@(posedge clk) disable iff (!rst_b) tgt_if.dv |-> |gnt);
  a_busy: assert property (@(posedge clk) disable iff (!rst_b) state_q != IDLE |-> arb_busy);
endmodule

// File: tb/tb_mci_cif_arb.sv
// tb_mci_cif_arb: scoreboard bench for the two-requester CIF arbiter
module tb_mci_cif_arb;
  import mci_pkg::*;
  localparam logic [31:0] A0  = 32'h00C0_0010;
  localparam logic [31:0] A1  = 32'h00C0_0020;
  localparam logic [31:0] TRD = 32'h5A5A_0001;
  typedef struct packed {
    logic        tdv;
    logic [31:0] taddr;
    logic        gid;
    logic        busy;
    logic        terr;
    logic        h0;
    logic        e0;
    logic [31:0] d0;
    logic        h1;
    logic        e1;
    logic [31:0] d1;
  } obs_t;
  logic clk = 1'b0;
  logic rst_b;
  logic grant_id, arb_busy, timeout_err;
  int checks = 0;
  int failures = 0;
  obs_t  eq[$];
  string nq[$];
  cif_if r0_if();
  cif_if r1_if();
  cif_if t_if();
  mci_cif_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req0_if    (r0_if),
    .req1_if    (r1_if),
    .tgt_if     (t_if),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  // c codes: 0 idle, 1 waiting (held off), 2 granted pass-through, 3 aborted
  function automatic obs_t mk(bit tdv, bit [31:0] ta, bit gid, bit busy, bit terr, bit th, int c0, int c1);
    obs_t o;
    o = '0;
    o.tdv = tdv; o.taddr = ta; o.gid = gid; o.busy = busy; o.terr = terr;
    o.h0 = c0 == 1 || (c0 == 2 && th); o.e0 = c0 == 3; o.d0 = c0 == 2 ? TRD : 32'h0;
    o.h1 = c1 == 1 || (c1 == 2 && th); o.e1 = c1 == 3; o.d1 = c1 == 2 ? TRD : 32'h0;
    return o;
  endfunction
  task automatic step(string nm, bit d0, bit d1, bit th, obs_t e);
    r0_if.dv = d0;
    r1_if.dv = d1;
    t_if.req_hold = th;
    nq.push_back(nm);
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        obs_t e, a;
        string nm;
        e  = eq.pop_front();
        nm = nq.pop_front();
        a  = {t_if.dv, t_if.req_data.addr, grant_id, arb_busy, timeout_err,
              r0_if.req_hold, r0_if.error, r0_if.rdata, r1_if.req_hold, r1_if.error, r1_if.rdata};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    rst_b = 1'b0;
    r0_if.dv = 1'b0; r0_if.req_data = '{addr: A0, write: 1'b0, wdata: 32'h0};
    r1_if.dv = 1'b0; r1_if.req_data = '{addr: A1, write: 1'b0, wdata: 32'h0};
    t_if.req_hold = 1'b0; t_if.rdata = TRD; t_if.error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0, 0, mk(0, A0, 0, 0, 0, 0, 0, 0));
    rst_b = 1'b1;
    step("single0", 1, 0, 0, mk(1, A0, 0, 0, 0, 0, 2, 0));
    step("rr1", 1, 1, 0, mk(1, A1, 1, 0, 0, 0, 1, 2));
    step("both_hold1", 1, 1, 1, mk(1, A0, 0, 0, 0, 1, 2, 1));
    step("gnt0_hold2", 1, 1, 1, mk(1, A0, 0, 1, 0, 1, 2, 1));
    step("gnt0_hold3", 1, 1, 1, mk(1, A0, 0, 1, 0, 1, 2, 1));
    step("gnt0_done", 1, 1, 0, mk(1, A0, 0, 1, 0, 0, 2, 1));
    step("loser1", 1, 1, 0, mk(1, A1, 1, 0, 0, 0, 1, 2));
    for (int i = 0; i < 10; i++) begin
      bit g;
      g = i[0];
      step("b2b", 1, 1, 0, mk(1, g ? A1 : A0, g, 0, 0, 0, g ? 1 : 2, g ? 2 : 1));
    end
    step("r1_only_hold", 0, 1, 1, mk(1, A1, 1, 0, 0, 1, 0, 2));
    step("drop_dv", 1, 0, 1, mk(0, A1, 1, 1, 0, 1, 1, 0));
    step("drop_done", 1, 0, 0, mk(0, A1, 1, 1, 0, 0, 1, 0));
    step("after_drop", 1, 0, 0, mk(1, A0, 0, 0, 0, 0, 2, 0));
    step("gnt1_enter", 1, 1, 1, mk(1, A1, 1, 0, 0, 1, 1, 2));
    rst_b = 1'b0;
    step("rst_in_gnt1", 1, 1, 1, mk(1, A1, 1, 1, 0, 1, 1, 2));
    rst_b = 1'b1;
    step("post_rst", 1, 1, 1, mk(1, A0, 0, 0, 0, 1, 2, 1));
`ifdef MCI_CIF_ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 4; i++) step("to_hold", 1, 1, 1, mk(1, A0, 0, 1, 0, 1, 2, 1));
    step("abort", 1, 1, 1, mk(0, A0, 0, 1, 1, 1, 3, 1));
    step("after_abort", 1, 1, 1, mk(1, A1, 1, 0, 0, 1, 1, 2));
    step("gnt1_done", 1, 1, 0, mk(1, A1, 1, 1, 0, 0, 1, 2));
`else
    for (int i = 0; i < 1000; i++) step("long_hold", 1, 1, 1, mk(1, A0, 0, 1, 0, 1, 2, 1));
    step("long_done", 1, 1, 0, mk(1, A0, 0, 1, 0, 0, 2, 1));
`endif
    step("no_req", 0, 0, 0, mk(0, A0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5 && eq.size() > 0; i++) @(negedge clk);
    #1;
    if (eq.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
